// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder among NUM_REQ requesters,
// with a single registered result stage and valid/ready handshakes on both sides.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_carry,
  output logic                       rsp_overflow,
  output logic [31:0]                accept_count
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_overflow_q, rsp_overflow_d;
  logic [31:0]      accept_count_q, accept_count_d;

  logic [IDW-1:0]   grant, g_hi, g_lo;
  logic             any_hi, any_vld, can_accept, accept;
  logic [WIDTH-1:0] a_sel, b_sel, sum;
  logic [WIDTH:0]   c;

  // Lowest valid index at or above ptr wins; otherwise wrap to lowest valid overall.
  always_comb begin
    g_hi    = '0;
    g_lo    = '0;
    any_hi  = 1'b0;
    any_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        g_lo    = IDW'(i);
        any_vld = 1'b1;
        if (i >= int'(ptr_q)) begin
          g_hi   = IDW'(i);
          any_hi = 1'b1;
        end
      end
    end
    grant = any_hi ? g_hi : g_lo;
  end

  assign can_accept = (state_q == EMPTY) | rsp_ready;
  assign accept     = rst_n & can_accept & any_vld;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDW'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a  (a_sel[i]),
      .b  (b_sel[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    rsp_id_d       = rsp_id_q;
    rsp_sum_d      = rsp_sum_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_overflow_d = rsp_overflow_q;
    accept_count_d = accept_count_q;
    if (accept) begin
      state_d        = FULL;
      ptr_d          = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      rsp_id_d       = grant;
      rsp_sum_d      = sum;
      rsp_carry_d    = c[WIDTH];
      rsp_overflow_d = c[WIDTH] ^ c[WIDTH-1];
      accept_count_d = accept_count_q + 32'd1;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= EMPTY;
      ptr_q          <= '0;
      rsp_id_q       <= '0;
      rsp_sum_q      <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_overflow_q <= 1'b0;
      accept_count_q <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      rsp_id_q       <= rsp_id_d;
      rsp_sum_q      <= rsp_sum_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_overflow_q <= rsp_overflow_d;
      accept_count_q <= accept_count_d;
    end
  end

  assign rsp_valid    = (state_q == FULL);
  assign rsp_id       = rsp_id_q;
  assign rsp_sum      = rsp_sum_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_overflow = rsp_overflow_q;
  assign accept_count = accept_count_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scenario bench for adder_share_arbiter: expected results queued on grant, popped as responses drain.
module tb_adder_share_arbiter;
  localparam int N   = 4;
  localparam int W   = 64;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_a = '0, req_b = '0;
  logic [N-1:0]     req_ready;
  logic             rsp_valid, rsp_ready = 1'b0;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_sum;
  logic             rsp_carry, rsp_overflow;
  logic [31:0]      accept_count;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           c;
    logic           v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .accept_count (accept_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Reference: widened add for carry, sign-bit rule for overflow.
  task automatic push_exp(input int id);
    logic [W-1:0] a, b;
    logic [W:0]   s;
    exp_t         e;
    a = req_a[id*W +: W];
    b = req_b[id*W +: W];
    s = {1'b0, a} + {1'b0, b};
    e.id  = IDW'(id);
    e.sum = s[W-1:0];
    e.c   = s[W];
    e.v   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    sb.push_back(e);
  endtask

  // Scoreboard: a response is consumed at the edge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_underflow: got id=%0d sum=%h with no expected entry", rsp_id, rsp_sum);
      end else begin
        e = sb.pop_front();
        if ({rsp_id, rsp_sum, rsp_carry, rsp_overflow} !== e)
          $display("FAIL rsp: got id=%0d sum=%h c=%b v=%b, want id=%0d sum=%h c=%b v=%b",
                   rsp_id, rsp_sum, rsp_carry, rsp_overflow, e.id, e.sum, e.c, e.v);
        else passed++;
      end
    end
  end

  task automatic test_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    #12;
    checks++; if (req_ready !== '0) $display("FAIL reset_ready: got %b want 0", req_ready); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rsp_valid); else passed++;
    checks++; if ({rsp_id, rsp_sum, rsp_carry, rsp_overflow} !== '0)
      $display("FAIL reset_rsp: got id=%0d sum=%h c=%b v=%b want all 0", rsp_id, rsp_sum, rsp_carry, rsp_overflow);
    else passed++;
    checks++; if (accept_count !== 32'd0) $display("FAIL reset_count: got %0d want 0", accept_count); else passed++;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < N; i++) set_req(i, W'(i * 100 + 1), W'(i + 16));
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready !== (N'(1) << (k % N)))
        $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, N'(1) << (k % N)); else passed++;
      push_exp(k % N);
      tick();
      checks++; if (accept_count !== 32'(k + 1))
        $display("FAIL rr_count%0d: got %0d want %0d", k, accept_count, k + 1); else passed++;
      checks++; if (rsp_id !== IDW'(k % N))
        $display("FAIL rr_id%0d: got %0d want %0d", k, rsp_id, k % N); else passed++;
    end
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rr_drain: got %b want 0", rsp_valid); else passed++;
  endtask

  task automatic test_basic();
    set_req(0, 64'd5, 64'd7);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL basic_grant: got %b want 0001", req_ready); else passed++;
    push_exp(0);
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", rsp_valid); else passed++;
    checks++; if ({rsp_id, rsp_sum, rsp_carry, rsp_overflow} !== {2'd0, 64'd12, 1'b0, 1'b0})
      $display("FAIL basic_rsp: got id=%0d sum=%0d c=%b v=%b want id=0 sum=12 c=0 v=0",
               rsp_id, rsp_sum, rsp_carry, rsp_overflow);
    else passed++;
    tick();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL basic_drain: got %b want 0", rsp_valid); else passed++;
  endtask

  task automatic test_flags();
    set_req(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    req_valid = 4'b0001;
    #1;
    push_exp(0);
    tick();
    set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    checks++; if ({rsp_sum, rsp_carry, rsp_overflow} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1})
      $display("FAIL ovf_pos: got sum=%h c=%b v=%b want 8000000000000000 c=0 v=1", rsp_sum, rsp_carry, rsp_overflow);
    else passed++;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL refill_grant: got %b want 0001", req_ready); else passed++;
    push_exp(0);
    tick();
    req_valid = '0;
    checks++; if ({rsp_sum, rsp_carry, rsp_overflow} !== {64'd0, 1'b1, 1'b0})
      $display("FAIL carry_out: got sum=%h c=%b v=%b want 0 c=1 v=0", rsp_sum, rsp_carry, rsp_overflow);
    else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_req(0, 64'd11, 64'd22);
    req_valid = 4'b0001;
    #1;
    push_exp(0);
    tick();
    set_req(1, 64'd100, 64'd200);
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== '0) $display("FAIL bp_ready%0d: got %b want 0", k, req_ready); else passed++;
      checks++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd0, 64'd33})
        $display("FAIL bp_hold%0d: got v=%b id=%0d sum=%0d want v=1 id=0 sum=33", k, rsp_valid, rsp_id, rsp_sum);
      else passed++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) $display("FAIL bp_refill: got %b want 0010", req_ready); else passed++;
    push_exp(1);
    tick();
    req_valid = '0;
    checks++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd1, 64'd300})
      $display("FAIL bp_next: got v=%b id=%0d sum=%0d want v=1 id=1 sum=300", rsp_valid, rsp_id, rsp_sum);
    else passed++;
    tick();
  endtask

  task automatic test_skip();
    rsp_ready = 1'b1;
    set_req(2, 64'd1, 64'd2);
    req_valid = 4'b0100;
    #1;
    push_exp(2);
    tick();
    set_req(1, 64'd3, 64'd4);
    set_req(3, 64'd5, 64'd6);
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b1000) $display("FAIL skip_g3: got %b want 1000", req_ready); else passed++;
    push_exp(3);
    tick();
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) $display("FAIL skip_g1: got %b want 0010", req_ready); else passed++;
    push_exp(1);
    tick();
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL skip_drain: got %b want 0", rsp_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    set_req(0, 64'd9, 64'd9);
    req_valid = 4'b0001;
    #1;
    push_exp(0);
    tick();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1) $display("FAIL mid_full: got %b want 1", rsp_valid); else passed++;
    #2;
    rst_n = 1'b0;
    sb.delete();
    req_valid = '1;
    #1;
    checks++; if ({rsp_valid, accept_count} !== {1'b0, 32'd0})
      $display("FAIL mid_reset: got v=%b count=%0d want v=0 count=0", rsp_valid, accept_count); else passed++;
    checks++; if (req_ready !== '0) $display("FAIL mid_ready: got %b want 0", req_ready); else passed++;
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL mid_ptr: got %b want 0001", req_ready); else passed++;
    push_exp(0);
    tick();
    req_valid = '0;
    checks++; if ({rsp_id, accept_count} !== {2'd0, 32'd1})
      $display("FAIL mid_after: got id=%0d count=%0d want id=0 count=1", rsp_id, accept_count); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_flags();
    test_backpressure();
    test_skip();
    test_reset_mid();
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    checks++; if (sb.size() != 0) $display("FAIL sb_leftover: %0d responses never seen", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
